// File: rtl/keylink_pkg.sv
// keylink shared definitions: head codes, FSM states, defaults.
// Used by both the keylink receiver and transmitter.
package keylink_pkg;

  localparam int unsigned MIN_HIGH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF    = 1200000;
  localparam int unsigned MAX_DIGITS_DEF = 9;

  localparam logic [2:0] HD_DIG0  = 3'b000;
  localparam logic [2:0] HD_DIG1  = 3'b001;
  localparam logic [2:0] HD_START = 3'b010;
  localparam logic [2:0] HD_END   = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_BODY
  } state_e;

endpackage

// File: rtl/keylink_strobe.sv
// keylink input synchronizer and strobe high-time qualifier.
// Emits one accept pulse per strobe held high MIN_HIGH cycles.
module keylink_strobe
  import keylink_pkg::*;
#(
  parameter int unsigned MIN_HIGH = MIN_HIGH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_i,
  output logic [2:0] symbol_o,
  output logic       accept_o
);

  localparam int unsigned CW = $clog2(MIN_HIGH + 1);

  logic [3:0]    s1_q, s2_q;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] hi_q, hi_d;
  logic          ctrl;

  assign ctrl     = s2_q[3];
  assign symbol_o = s2_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      hi_q    <= hi_d;
    end
  end

  // Arm only on a genuine low seen after the sync chain has filled.
  always_comb begin
    armed_d  = armed_q;
    hi_d     = hi_q;
    accept_o = 1'b0;
    if (!ctrl) begin
      hi_d = '0;
      if (fill_q[1]) armed_d = 1'b1;
    end else if (armed_q) begin
      if (hi_q != CW'(MIN_HIGH)) hi_d = hi_q + CW'(1);
      accept_o = (hi_q == CW'(MIN_HIGH - 1));
    end
  end

endmodule

// File: rtl/keylink_rx.sv
// keylink receiver: decodes head/body symbol pairs into digits
// and START/digits/END frames into 32-bit decimal numbers.
module keylink_rx
  import keylink_pkg::*;
#(
  parameter int unsigned MIN_HIGH   = MIN_HIGH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic        hwclk,
  input  logic        resetN,
  input  logic        in0,
  input  logic        in1,
  input  logic        in2,
  input  logic        inControl,
  output logic [3:0]  digit,
  output logic        digitValid,
  output logic [31:0] number,
  output logic        numberValid,
  output logic        frameError,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

  logic [2:0] sym;
  logic       acc;

  keylink_strobe #(.MIN_HIGH(MIN_HIGH)) u_strobe (
    .clk      (hwclk),
    .rst_n    (resetN),
    .raw_i    ({inControl, in2, in1, in0}),
    .symbol_o (sym),
    .accept_o (acc)
  );

  state_e        state_q, state_d;
  logic          hb_q, hb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   acc_q, acc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          innum_q, innum_d;
  logic [3:0]    digit_q, digit_d;
  logic [31:0]   number_q, number_d;
  logic          dv_q, dv_d;
  logic          nv_q, nv_d;
  logic          fe_q, fe_d;
  logic          err;
  logic [3:0]    d;

  assign d           = {hb_q, sym};
  assign digit       = digit_q;
  assign digitValid  = dv_q;
  assign number      = number_q;
  assign numberValid = nv_q;
  assign frameError  = fe_q;
  assign busy        = (state_q == ST_WAIT_BODY) | innum_q;

  always_ff @(posedge hwclk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      hb_q     <= 1'b0;
      tmo_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      innum_q  <= 1'b0;
      digit_q  <= '0;
      number_q <= '0;
      dv_q     <= 1'b0;
      nv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hb_q     <= hb_d;
      tmo_q    <= tmo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      innum_q  <= innum_d;
      digit_q  <= digit_d;
      number_q <= number_d;
      dv_q     <= dv_d;
      nv_q     <= nv_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hb_d     = hb_q;
    tmo_d    = tmo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    innum_d  = innum_q;
    digit_d  = digit_q;
    number_d = number_q;
    dv_d     = 1'b0;
    nv_d     = 1'b0;
    fe_d     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          unique case (sym)
            HD_DIG0, HD_DIG1: begin
              state_d = ST_WAIT_BODY;
              hb_d    = sym[0];
              tmo_d   = TW'(TIMEOUT - 1);
            end
            HD_START: begin
              acc_d   = '0;
              cnt_d   = '0;
              innum_d = 1'b1;
            end
            HD_END: begin
              if (innum_q) begin
                number_d = acc_q;
                nv_d     = 1'b1;
                innum_d  = 1'b0;
              end else begin
                err = 1'b1;
              end
            end
            default: err = 1'b1;
          endcase
        end
      end
      ST_WAIT_BODY: begin
        // Expiry wins over a body landing on the same cycle.
        if (tmo_q == '0) begin
          err = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
          if (acc) begin
            state_d = ST_IDLE;
            if (!innum_q) begin
              digit_d = d;
              dv_d    = 1'b1;
            end else if (d > 4'd9 || cnt_q == DW'(MAX_DIGITS)) begin
              err = 1'b1;
            end else begin
              acc_d   = acc_q * 32'd10 + {28'd0, d};
              cnt_d   = cnt_q + DW'(1);
              digit_d = d;
              dv_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (err) begin
      fe_d    = 1'b1;
      state_d = ST_IDLE;
      innum_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_keylink_rx.sv
// keylink_rx bench: symbol driver plus digit/number scoreboards.
// Timeout shortened so the run stays short.
module tb_keylink_rx;

  localparam int TMO = 1500;

  logic        hwclk = 1'b0;
  logic        resetN = 1'b0;
  logic        in0 = 1'b0, in1 = 1'b0, in2 = 1'b0;
  logic        inControl = 1'b0;
  logic [3:0]  digit;
  logic        digitValid;
  logic [31:0] number;
  logic        numberValid;
  logic        frameError;
  logic        busy;

  keylink_rx #(
    .MIN_HIGH   (4),
    .TIMEOUT    (TMO),
    .MAX_DIGITS (9)
  ) dut (
    .hwclk       (hwclk),
    .resetN      (resetN),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .inControl   (inControl),
    .digit       (digit),
    .digitValid  (digitValid),
    .number      (number),
    .numberValid (numberValid),
    .frameError  (frameError),
    .busy        (busy)
  );

  always #5 hwclk = ~hwclk;

  int n_chk = 0;
  int n_err = 0;
  int seen_err = 0;
  int exp_err = 0;
  logic [3:0]  dq[$];
  logic [31:0] nq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge hwclk) begin
    if (resetN) begin
      if (digitValid) begin
        if (dq.size() == 0) chk("digit_unexpected", 1, 0);
        else chk("digit", {28'd0, digit}, {28'd0, dq.pop_front()});
      end
      if (numberValid) begin
        if (nq.size() == 0) chk("number_unexpected", 1, 0);
        else chk("number", number, nq.pop_front());
      end
      if (frameError) seen_err++;
    end
  end

  task automatic send_sym(input logic [2:0] s, input int hold = 10);
    @(negedge hwclk);
    {in2, in1, in0} = s;
    inControl = 1'b1;
    repeat (hold) @(negedge hwclk);
    inControl = 1'b0;
    repeat (10) @(negedge hwclk);
  endtask

  task automatic send_digit(input logic [3:0] dv, input bit ok = 1'b1,
                            input int hold = 10);
    if (ok) dq.push_back(dv);
    send_sym({2'b00, dv[3]}, hold);
    send_sym(dv[2:0], hold);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_digit"}, {28'd0, digit}, 0);
    chk({tag, "_number"}, number, 0);
    chk({tag, "_pulses"}, {29'd0, digitValid, numberValid, frameError}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  int unsigned model;
  logic [3:0] seq[6] = '{4'd5, 4'd5, 4'd5, 4'd1, 4'd1, 4'd6};

  initial begin
    repeat (3) @(negedge hwclk);
    chk_outs_zero("reset");
    resetN = 1'b1;
    repeat (5) @(negedge hwclk);

    // Standalone digit 5
    send_digit(4'd5);
    chk("solo_busy", {31'd0, busy}, 0);
    chk("solo_ferr", seen_err, exp_err);

    // Glitch filter: 3-cycle START ignored, so END is an error
    send_sym(3'b010, 3);
    chk("glitch_busy", {31'd0, busy}, 0);
    send_sym(3'b100, 4);
    exp_err++;
    chk("glitch_end_err", seen_err, exp_err);
    send_digit(4'd3, 1'b1, 4);
    chk("min_high_ferr", seen_err, exp_err);

    // Number 555116
    send_sym(3'b010);
    chk("innum_busy", {31'd0, busy}, 1);
    model = 0;
    foreach (seq[i]) begin
      send_digit(seq[i]);
      model = model * 10 + seq[i];
    end
    nq.push_back(model);
    send_sym(3'b100);
    chk("num_value", number, 32'd555116);
    chk("num_busy", {31'd0, busy}, 0);
    chk("num_ferr", seen_err, exp_err);

    // Keys 10 and 11 are plain keys outside a number
    send_digit(4'd10);
    send_digit(4'd11);
    chk("key_ferr", seen_err, exp_err);

    // Digit 11 inside a number
    send_sym(3'b010);
    send_digit(4'd11, 1'b0);
    exp_err++;
    chk("range_err", seen_err, exp_err);
    chk("range_num_kept", number, 32'd555116);
    chk("range_busy", {31'd0, busy}, 0);

    // Exactly MAX_DIGITS digits is fine
    send_sym(3'b010);
    model = 0;
    for (int i = 0; i < 9; i++) begin
      send_digit(4'd9);
      model = model * 10 + 9;
    end
    nq.push_back(model);
    send_sym(3'b100);
    chk("max_digits_num", number, 32'd999999999);
    chk("max_digits_ferr", seen_err, exp_err);

    // Tenth digit is an error; following END is then also an error
    send_sym(3'b010);
    for (int i = 0; i < 9; i++) send_digit(4'((i % 9) + 1));
    send_digit(4'd7, 1'b0);
    exp_err++;
    chk("count_err", seen_err, exp_err);
    send_sym(3'b100);
    exp_err++;
    chk("end_after_err", seen_err, exp_err);
    chk("count_num_kept", number, 32'd999999999);

    // Timeout in WAIT_BODY
    send_sym(3'b000);
    chk("tmo_wait_busy", {31'd0, busy}, 1);
    repeat (TMO - 60) @(negedge hwclk);
    chk("tmo_early_busy", {31'd0, busy}, 1);
    chk("tmo_early_ferr", seen_err, exp_err);
    repeat (100) @(negedge hwclk);
    exp_err++;
    chk("tmo_err", seen_err, exp_err);
    chk("tmo_busy", {31'd0, busy}, 0);

    // Reset during WAIT_BODY, line already high at release
    send_sym(3'b000);
    chk("rst_pre_busy", {31'd0, busy}, 1);
    {in2, in1, in0} = 3'b101;
    inControl = 1'b1;
    #2 resetN = 1'b0;
    #1 chk_outs_zero("async_rst");
    repeat (3) @(negedge hwclk);
    resetN = 1'b1;
    repeat (12) @(negedge hwclk);
    inControl = 1'b0;
    repeat (10) @(negedge hwclk);
    chk("held_high_ignored", seen_err, exp_err);
    send_sym(3'b101);
    exp_err++;
    chk("body_as_head_err", seen_err, exp_err);
    chk("post_rst_busy", {31'd0, busy}, 0);

    repeat (20) @(negedge hwclk);
    chk("digit_q_drained", dq.size(), 0);
    chk("number_q_drained", nq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/keylink_rx.md
KEYLINK_RX -- requirements
Module: keylink_rx

Interface
REQ-001 SHALL have parameter MIN_HIGH, default 4: consecutive synchronized cycles inControl must be high before a symbol is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 1200000: cycles allowed between the head and body symbols (100 ms at 12 MHz).
REQ-003 SHALL have parameter MAX_DIGITS, default 9: maximum decimal digits per number.
REQ-004 SHALL have port hwclk, input, 1 bit: the single clock, 12 MHz.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports in0, in1, in2, input, 1 bit each: data lines, in0 = LSB.
REQ-007 SHALL have port inControl, input, 1 bit: symbol strobe.
REQ-008 SHALL have port digit, output, 4 bits: last received digit code (0-11).
REQ-009 SHALL have port digitValid, output, 1 bit: one-cycle pulse when digit updates.
REQ-010 SHALL have port number, output, 32 bits: last completed number.
REQ-011 SHALL have port numberValid, output, 1 bit: one-cycle pulse when number updates.
REQ-012 SHALL have port frameError, output, 1 bit: one-cycle pulse on any protocol error.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame or number is in progress.

Function
REQ-014 SHALL pass all four inputs through a 2-flop synchronizer before use.
REQ-015 SHALL accept a symbol exactly once per strobe: on the cycle the synchronized inControl has been high for MIN_HIGH consecutive cycles following a low, sampling the synchronized {in2,in1,in0} on that cycle.
REQ-016 SHALL ignore a high pulse shorter than MIN_HIGH cycles and raise no error for it.
REQ-017 SHALL decode head symbols in IDLE as follows: 3'b000 = digit head with d[3]=0; 3'b001 = digit head with d[3]=1; 3'b010 = START; 3'b100 = END; any other value is an error.
REQ-018 SHALL, on a digit head, enter WAIT_BODY and load the timeout counter.
REQ-019 SHALL, in WAIT_BODY, form d = {head bit0, body[2:0]} from the next accepted symbol, update digit, pulse digitValid 1 cycle later, and return to IDLE.
REQ-020 SHALL, on START, clear the accumulator and digit count and set the in-number flag; a START received while already in-number restarts the number silently.
REQ-021 SHALL, while in-number, set the accumulator to accumulator*10 + d for each digit, computed at 32-bit width with wrap-around permitted.
REQ-022 SHALL, on END while in-number, copy the accumulator to number, pulse numberValid, and clear the in-number flag.
REQ-023 SHALL treat END while not in-number as an error.
REQ-024 SHALL treat each of the following as an error: d > 9 while in-number; a digit that would exceed MAX_DIGITS; WAIT_BODY reaching the end of TIMEOUT cycles.
REQ-025 SHALL, while not in-number, report digits 10 and 11 normally as standalone keys.
REQ-026 SHALL, on any error, pulse frameError, return to IDLE, clear the in-number flag, and leave number unchanged.
REQ-027 SHALL let a timeout expiring in the same cycle as a body acceptance take priority; the body is discarded.
REQ-028 SHALL drive busy = (state == WAIT_BODY) | in-number.

Reset
REQ-029 SHALL, on resetN low, asynchronously set: state IDLE, synchronizers 0, digit 0, number 0, all pulses 0, busy 0, accumulator 0, counters 0, in-number flag 0.
REQ-030 SHALL treat control as low after reset, so a line already high at release is not accepted until it goes low and high again.

Structure
REQ-031 SHALL place the head codes, the state enumeration, and the default MIN_HIGH, TIMEOUT, and MAX_DIGITS values in shared package keylink_pkg, which the transmitter also uses.
REQ-032 SHALL implement the synchronizer plus high-time qualifier as sub-module keylink_strobe, which outputs symbol[2:0] and a one-cycle accept pulse.

Verification
REQ-033 SHALL verify a standalone digit: head 3'b000 then body 3'b101, each held high 10 cycles -> digit=5 with one digitValid pulse and no error.
REQ-034 SHALL verify a number: START, digits 5,5,5,1,1,6, END -> number=555116 and one numberValid pulse.
REQ-035 SHALL verify the glitch filter: inControl high for 3 cycles -> no acceptance; high for 4 cycles -> exactly one acceptance.
REQ-036 SHALL verify the timeout: digit head followed by no body for 1200000 cycles -> frameError pulse and busy=0.
REQ-037 SHALL verify range and count errors: START, digit 11 -> frameError and number unchanged; START, then 10 digits -> frameError on the 10th.
REQ-038 SHALL verify reset mid-operation: resetN low during WAIT_BODY -> all outputs 0 immediately; the following body symbol is decoded as a head.
